// File: rtl/jk_eval_pkg.sv
// jk_eval_pkg: shared types and constants for the JK evaluation harness.
//   state_t           harness FSM states
//   JK_*              dut_in encodings, bit0 = J, bit1 = K
//   LFSR_DEFAULT_SEED seed used at reset and in place of a zero seed
//   NO_FAIL           first_fail value when no vector has mismatched
//   lfsr_next()       one step of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   jk_expect()       JK next-state rule given inputs and current state
package jk_eval_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        APPLY  = 3'd2,
        SETTLE = 3'd3,
        SAMPLE = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b01;
    localparam logic [1:0] JK_RST  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;
    localparam logic [7:0] NO_FAIL           = 8'hFF;

    // Shift left, feedback into bit 0. Taps 8,6,5,4 are bits 7,5,4,3.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic jk_expect(input logic [1:0] jk, input logic q);
        case (jk)
            JK_SET:  return 1'b1;
            JK_RST:  return 1'b0;
            JK_HOLD: return q;
            default: return ~q;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
//   clk      in  sampling clock
//   reset_n  in  asynchronous active-low reset, both flops clear to 0
//   d        in  asynchronous input
//   q        out synchronised output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/jk_eval_harness.sv
// jk_eval_harness: drives an evolved 2-input JK circuit with LFSR vectors,
// synchronises its asynchronous output and scores it against a JK model.
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   start         in   1-cycle pulse, begins a run when idle
//   seed[7:0]     in   LFSR seed captured on accepted start (0 -> 8'hA5)
//   dut_in[1:0]   out  registered stimulus, J = bit0, K = bit1
//   dut_out       in   circuit output, asynchronous to clk
//   busy          out  high from accepted start until done
//   done          out  1-cycle pulse at end of run
//   pass          out  no mismatches and no oscillation in last run
//   mismatch_cnt  out  scored vectors that mismatched, saturating
//   first_fail    out  index of first mismatching vector, 8'hFF if none
//   osc_flag      out  some vector produced more than OSC_LIMIT edges
module jk_eval_harness
    import jk_eval_pkg::*;
#(
    parameter int NUM_VECTORS   = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int OSC_LIMIT     = 2,
    parameter bit CHECK_TOGGLE  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] seed,
    output logic [1:0] dut_in,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] mismatch_cnt,
    output logic [7:0] first_fail,
    output logic       osc_flag
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t           state;
    logic [7:0]       lfsr;
    logic [7:0]       vec_idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       edge_cnt;
    logic             model_q;

    logic q_s;
    logic q_s_d;
    logic sync_edge;

    logic expected;
    logic scored;
    logic osc_hit;
    logic bad;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (dut_out),
        .q       (q_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_s_d <= 1'b0;
        else          q_s_d <= q_s;
    end

    assign sync_edge = q_s ^ q_s_d;

    // Scoring decision for the vector currently held on dut_in.
    assign expected = jk_expect(dut_in, model_q);
    assign scored   = CHECK_TOGGLE || (dut_in != JK_TOG);
    assign osc_hit  = (int'(edge_cnt) > OSC_LIMIT);
    assign bad      = scored && ((q_s != expected) || osc_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            dut_in       <= JK_HOLD;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= 8'd0;
            first_fail   <= NO_FAIL;
            osc_flag     <= 1'b0;
            model_q      <= 1'b0;
            lfsr         <= LFSR_DEFAULT_SEED;
            vec_idx      <= 8'd0;
            cnt          <= '0;
            edge_cnt     <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr         <= (seed == 8'h00) ? LFSR_DEFAULT_SEED : seed;
                        mismatch_cnt <= 8'd0;
                        first_fail   <= NO_FAIL;
                        osc_flag     <= 1'b0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        vec_idx      <= 8'd0;
                        cnt          <= '0;
                        model_q      <= 1'b0;
                        // K only, forces the circuit to a known 0 before vectors.
                        dut_in       <= JK_RST;
                        state        <= INIT;
                    end
                end

                // SETTLE_CYCLES+1 cycles of reset drive, unscored.
                INIT: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES)) begin
                        cnt   <= '0;
                        state <= APPLY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                APPLY: begin
                    dut_in   <= lfsr[1:0];
                    cnt      <= '0;
                    edge_cnt <= 4'd0;
                    state    <= SETTLE;
                end

                SETTLE: begin
                    // Edges seen in the first two settle cycles are still the
                    // previous vector's activity emerging from the synchroniser;
                    // only edges caused by this vector's input change are counted.
                    if (sync_edge && (cnt >= CNT_W'(2)) && (edge_cnt != 4'hF))
                        edge_cnt <= edge_cnt + 4'd1;
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SAMPLE: begin
                    if (osc_hit)
                        osc_flag <= 1'b1;
                    if (bad) begin
                        if (mismatch_cnt != 8'hFF)
                            mismatch_cnt <= mismatch_cnt + 8'd1;
                        if (first_fail == NO_FAIL)
                            first_fail <= vec_idx;
                    end
                    // Unscored toggles resync the model to what the circuit did.
                    model_q <= scored ? expected : q_s;
                    if (vec_idx == 8'(NUM_VECTORS - 1)) begin
                        state <= FINISH;
                    end else begin
                        vec_idx <= vec_idx + 8'd1;
                        lfsr    <= lfsr_next(lfsr);
                        state   <= APPLY;
                    end
                end

                FINISH: begin
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    pass   <= (mismatch_cnt == 8'd0) && !osc_flag;
                    dut_in <= JK_HOLD;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
